// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: owner and FSM encodings,
// access-size codes and the latched memory request record.
package riscv_pkg;

   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

   localparam logic [2:0] SZ_B = 3'd0;
   localparam logic [2:0] SZ_H = 3'd1;
   localparam logic [2:0] SZ_W = 3'd2;
   localparam logic [2:0] SZ_D = 3'd3;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        we;
      logic [2:0]  size;
   } mem_req_t;

endpackage

// File: rtl/riscv_mem_arbiter_arb.sv
// Data-priority grant with a starvation cap: after MAX_DATA_STREAK data grants
// taken while fetch was waiting, the next contested grant goes to fetch.
module arb_prio_streak #(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_if_valid,
   input  logic i_d_valid,
   output logic o_gnt_if,
   output logic o_gnt_d
);

   localparam logic [7:0] LP_MAX = 8'(MAX_DATA_STREAK);

   logic [7:0] r_streak;
   logic       w_force_if;

   assign w_force_if = i_if_valid && (r_streak == LP_MAX);
   assign o_gnt_d    = i_en && i_d_valid && !w_force_if;
   assign o_gnt_if   = i_en && i_if_valid && (!i_d_valid || w_force_if);

   // Only data grants that actually made fetch wait count toward the streak
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_streak <= '0;
      end else if (o_gnt_if) begin
         r_streak <= '0;
      end else if (o_gnt_d) begin
         if (!i_if_valid)
            r_streak <= '0;
         else if (r_streak != LP_MAX)
            r_streak <= r_streak + 8'd1;
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port 64-bit memory between instruction fetch and data
// access, one transaction in flight, with a response watchdog.
module riscv_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [63:0] if_req_addr,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_instr,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic [63:0] d_req_addr,
   input  logic [63:0] d_req_wdata,
   input  logic        d_req_we,
   input  logic [2:0]  d_req_size,
   output logic        d_resp_valid,
   output logic [63:0] d_resp_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic        mem_req_we,
   output logic [2:0]  mem_req_size,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_rdata,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   owner_t      r_owner;
   mem_req_t    r_req;
   logic [15:0] r_timer;
   logic        r_if_resp_valid, r_d_resp_valid, r_timeout_err;
   logic [31:0] r_if_resp_instr;
   logic [63:0] r_d_resp_rdata;
   logic        w_gnt_if, w_gnt_d, w_arb_en, w_resp_hit, w_tmo, w_done;

   // Ready is gated by reset so the requesters see nothing while it is held
   assign w_arb_en = (r_state == IDLE) && rst_n;

   arb_prio_streak #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (w_arb_en),
      .i_if_valid (if_req_valid),
      .i_d_valid  (d_req_valid),
      .o_gnt_if   (w_gnt_if),
      .o_gnt_d    (w_gnt_d)
   );

   // A real response in the final watchdog cycle beats the timeout
   assign w_resp_hit = (r_state == RESP) && mem_resp_valid;
   assign w_tmo      = (r_state == RESP) && !mem_resp_valid && (r_timer == LP_TMO_LAST);
   assign w_done     = w_resp_hit || w_tmo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_gnt_if || w_gnt_d) w_state_nxt = REQ;
         REQ:     if (mem_req_ready)       w_state_nxt = RESP;
         RESP:    if (w_done)              w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req   <= '0;
         r_owner <= OWN_IF;
      end else if (w_gnt_d) begin
         r_req   <= '{addr: d_req_addr, wdata: d_req_wdata, we: d_req_we, size: d_req_size};
         r_owner <= OWN_D;
      end else if (w_gnt_if) begin
         r_req   <= '{addr: if_req_addr, wdata: 64'd0, we: 1'b0, size: SZ_W};
         r_owner <= OWN_IF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              r_timer <= '0;
      else if (r_state == REQ && mem_req_ready) r_timer <= '0;
      else if (r_state == RESP)                r_timer <= r_timer + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_resp_valid <= 1'b0;
         r_d_resp_valid  <= 1'b0;
         r_if_resp_instr <= '0;
         r_d_resp_rdata  <= '0;
         r_timeout_err   <= 1'b0;
      end else begin
         r_if_resp_valid <= w_done && (r_owner == OWN_IF);
         r_d_resp_valid  <= w_done && (r_owner == OWN_D);
         if (w_done && r_owner == OWN_IF)
            r_if_resp_instr <= w_tmo ? 32'd0 :
                               (r_req.addr[2] ? mem_resp_rdata[63:32] : mem_resp_rdata[31:0]);
         if (w_done && r_owner == OWN_D)
            r_d_resp_rdata  <= (w_tmo || r_req.we) ? 64'd0 : mem_resp_rdata;
         if (w_tmo)
            r_timeout_err   <= 1'b1;
      end
   end

   assign if_req_ready  = w_gnt_if;
   assign d_req_ready   = w_gnt_d;
   assign if_resp_valid = r_if_resp_valid;
   assign if_resp_instr = r_if_resp_instr;
   assign d_resp_valid  = r_d_resp_valid;
   assign d_resp_rdata  = r_d_resp_rdata;
   assign mem_req_valid = (r_state == REQ);
   assign mem_req_addr  = r_req.addr;
   assign mem_req_wdata = r_req.wdata;
   assign mem_req_we    = r_req.we;
   assign mem_req_size  = r_req.size;
   assign busy          = (r_state != IDLE);
   assign timeout_err   = r_timeout_err;

endmodule
